spin_pulse_sequencer: RTL

- Upstream feeder for the DAC output scaler.
- Holds a host-programmed table of spin amplitudes written over the shared 32-bit GPIO bus.
- On a trigger, replays the table as a stream of single-cycle val_out/val_out_valid beats. Beats are separated by a programmable number of idle cycles and the whole table can be repeated for several passes.
- Its outputs connect directly to the scaler's val_in/val_in_valid.

---
 rtl/spin_pulse_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spin_pulse_sequencer.sv
// Replays a host-loaded amplitude table as single-cycle val_out/val_out_valid beats.
// Beats are spaced by a programmable gap, and the table can be repeated for several passes.
module spin_pulse_sequencer #(
  parameter int          depth    = 256,
  parameter int          data_w   = 8,
  parameter logic [15:0] reg_base = 16'h1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       gpio_in,
  input  logic              trig,
  output logic [data_w-1:0] val_out,
  output logic              val_out_valid,
  output logic              busy,
  output logic              done
);
  localparam int AW = $clog2(depth);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_DONE} state_t;

  state_t            r_state;
  logic              r_wclk;
  logic [7:0]        r_len, r_gap, r_reps, r_pass, r_gcnt;
  logic [AW-1:0]     r_idx;
  logic [data_w-1:0] r_val;
  logic              r_valid, r_busy, r_done;
  logic [data_w-1:0] r_mem [depth];

  logic [15:0]   w_addr;
  logic [7:0]    w_data;
  logic          w_wr, w_mem_wr, w_ctrl, w_abort, w_start;
  logic [LW-1:0] w_len_eff;
  logic          w_idx_end, w_last;
  logic [AW-1:0] w_nidx, w_rd_addr;
  logic [7:0]    w_npass;
  logic          w_rd_en;
  logic          w_unused;

  assign w_unused  = ^gpio_in[31:25];
  assign w_addr    = gpio_in[15:0];
  assign w_data    = gpio_in[23:16];
  assign w_wr      = gpio_in[24] & ~r_wclk;
  assign w_mem_wr  = w_wr & ~r_busy & (32'(w_addr) < 32'(depth));
  assign w_ctrl    = w_wr & (w_addr == reg_base + 16'd3);
  assign w_abort   = w_ctrl & w_data[1];
  assign w_start   = (trig | (w_ctrl & w_data[0])) & ~w_abort;

  assign w_len_eff = (32'(r_len) > 32'(depth)) ? LW'(depth) : LW'(r_len);
  assign w_idx_end = (LW'(r_idx) == w_len_eff - LW'(1));
  assign w_last    = w_idx_end & (r_pass == r_reps);
  assign w_nidx    = w_idx_end ? '0 : r_idx + AW'(1);
  assign w_npass   = w_idx_end ? r_pass + 8'd1 : r_pass;

  // The output register doubles as the RAM read port: the next sample is
  // fetched on the edge that starts its beat, so gap=0 streams without bubbles.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    case (r_state)
      S_IDLE: w_rd_en = w_start & (w_len_eff != '0);
      S_PLAY: begin
        w_rd_en   = ~w_abort & ~w_last & (r_gap == 8'd0);
        w_rd_addr = w_nidx;
      end
      S_GAP: begin
        w_rd_en   = ~w_abort & (r_gcnt == 8'd0);
        w_rd_addr = r_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_mem_wr) r_mem[w_addr[AW-1:0]] <= w_data[data_w-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wclk  <= 1'b0;
      r_len   <= '0;
      r_gap   <= '0;
      r_reps  <= '0;
      r_pass  <= '0;
      r_gcnt  <= '0;
      r_idx   <= '0;
      r_val   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wclk <= gpio_in[24];
      r_done <= 1'b0;
      if (w_wr & ~r_busy) begin
        if (w_addr == reg_base)         r_len  <= w_data;
        if (w_addr == reg_base + 16'd1) r_gap  <= w_data;
        if (w_addr == reg_base + 16'd2) r_reps <= w_data;
      end
      if (w_rd_en) r_val <= r_mem[w_rd_addr];
      case (r_state)
        S_IDLE: if (w_start) begin
          r_idx  <= '0;
          r_pass <= '0;
          if (w_len_eff == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_PLAY;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
          end
        end
        S_PLAY: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
          end else if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx  <= w_nidx;
            r_pass <= w_npass;
            if (r_gap != 8'd0) begin
              r_state <= S_GAP;
              r_valid <= 1'b0;
              r_gcnt  <= r_gap - 8'd1;
            end
          end
        end
        S_GAP: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_gcnt == 8'd0) begin
            r_state <= S_PLAY;
            r_valid <= 1'b1;
          end else begin
            r_gcnt <= r_gcnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign val_out       = r_val;
  assign val_out_valid = r_valid;
  assign busy          = r_busy;
  assign done          = r_done;
endmodule
